// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: control, status and gate-drive bundle between a test master, the BIST sequencer and one gate
//   start, abort        : run control from the test master
//   gate_y              : output of the gate under test, read by the sequencer
//   gate_a, gate_b      : drive to the gate inputs A and B
//   busy, done, pass    : run status; pass valid while done
//   fail_vec, fail_y    : {B,A} index and captured gate_y of the first mismatch
interface gate_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       gate_y;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] fail_vec;
    logic       fail_y;
    modport master (
        output start, abort, gate_y,
        input  gate_a, gate_b, busy, done, pass, fail_vec, fail_y
    );
    modport slave (
        input  start, abort, gate_y,
        output gate_a, gate_b, busy, done, pass, fail_vec, fail_y
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer walking a 2-input gate through all four input vectors against a truth table
//   clk   : rising-edge clock
//   rst_  : asynchronous active-low reset
//   bus   : slave side of gate_bist_ctrl_if (start/abort/gate_y in; gate drive, status and result out)
//   TRUTH : expected gate_y indexed by {B,A}
//   SETTLE: cycles each vector is held before its compare cycle (1..15)
module gate_bist_ctrl #(
    parameter logic [3:0] TRUTH  = 4'b1110,
    parameter logic [3:0] SETTLE = 4'd2
) (
    input logic             clk,
    input logic             rst_,
    gate_bist_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0] state;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic       pass;
    logic [1:0] fail_vec;
    logic       fail_y;
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            vec      <= 2'd0;
            cnt      <= 4'd0;
            pass     <= 1'b0;
            fail_vec <= 2'd0;
            fail_y   <= 1'b0;
        end else if (bus.abort) begin
            state    <= IDLE;
            vec      <= 2'd0;
            cnt      <= 4'd0;
            pass     <= 1'b0;
            fail_vec <= 2'd0;
            fail_y   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state    <= WAIT;
                    vec      <= 2'd0;
                    cnt      <= SETTLE;
                    pass     <= 1'b0;
                    fail_vec <= 2'd0;
                    fail_y   <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) state <= CHECK;
                end
                default: begin
                    // case-equality so an X or Z from the gate counts as a mismatch
                    if (bus.gate_y !== TRUTH[vec]) begin
                        state    <= DONE;
                        fail_vec <= vec;
                        fail_y   <= bus.gate_y;
                    end else if (vec == 2'd3) begin
                        state <= DONE;
                        pass  <= 1'b1;
                    end else begin
                        state <= WAIT;
                        vec   <= vec + 1'b1;
                        cnt   <= SETTLE;
                    end
                end
            endcase
        end
    end
    // gate drive is the vector register itself, so it only moves on entry to WAIT
    assign bus.gate_a   = vec[0];
    assign bus.gate_b   = vec[1];
    assign bus.busy     = (state == WAIT) || (state == CHECK);
    assign bus.done     = state == DONE;
    assign bus.pass     = pass;
    assign bus.fail_vec = fail_vec;
    assign bus.fail_y   = fail_y;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed bench for gate_bist_ctrl with gate models and an expected-result queue
module tb_gate_bist_ctrl;
    localparam int S = 2;
    typedef struct packed {
        logic [7:0] edges;
        logic       pass;
        logic [1:0] fv;
        logic       fy;
    } exp_t;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic xv;
    int   mode0 = 0;
    int   mode1 = 3;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];
    gate_bist_ctrl_if bus0 ();
    gate_bist_ctrl_if bus1 ();
    gate_bist_ctrl dut_or (.clk(clk), .rst_(rst_), .bus(bus0));
    gate_bist_ctrl #(.TRUTH(4'b1000), .SETTLE(4'd2)) dut_and (.clk(clk), .rst_(rst_), .bus(bus1));
    always #5 clk = ~clk;
    // 0: or2, 1: output stuck at 0, 2: or2 but X for A=B=1, 3: and2
    function automatic logic model(input int m, input logic a, input logic b, input logic x);
        case (m)
            0: return a | b;
            1: return 1'b0;
            2: return (a & b) ? x : (a | b);
            default: return a & b;
        endcase
    endfunction
    assign bus0.gate_y = model(mode0, bus0.gate_a, bus0.gate_b, xv);
    assign bus1.gate_y = model(mode1, bus1.gate_a, bus1.gate_b, xv);
    wire [7:0] o0 = {bus0.busy, bus0.done, bus0.pass, bus0.fail_vec, bus0.fail_y, bus0.gate_b, bus0.gate_a};
    wire [7:0] o1 = {bus1.busy, bus1.done, bus1.pass, bus1.fail_vec, bus1.fail_y, bus1.gate_b, bus1.gate_a};
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic set_start(input bit d, input logic v);
        if (d) bus1.start = v;
        else bus0.start = v;
    endtask
    task automatic run(input bit d, input int m, input int ee, input logic ep,
                       input logic [1:0] efv, input logic efy, input bit mid);
        exp_t x;
        int e;
        logic [7:0] o;
        if (d) mode1 = m;
        else mode0 = m;
        q.push_back('{edges: 8'(ee), pass: ep, fv: efv, fy: efy});
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        e = 0;
        forever begin
            o = d ? o1 : o0;
            if (o[6] || e >= 100) break;
            if (e % (S + 1) == 0) begin
                chk("busy_run", {7'd0, o[7]}, 8'd1);
                chk("vec_applied", {6'd0, o[1:0]}, 8'(e / (S + 1)));
            end
            @(negedge clk);
            e++;
            if (mid) set_start(d, e == 4);
        end
        x = q.pop_front();
        chk("done_edge", 8'(e), x.edges);
        chk("done", {7'd0, o[6]}, 8'd1);
        chk("pass", {7'd0, o[5]}, {7'd0, x.pass});
        chk("fail_vec", {6'd0, o[4:3]}, {6'd0, x.fv});
        chk("fail_y", {7'd0, o[2]}, {7'd0, x.fy});
        chk("held_vec", {6'd0, o[1:0]}, {6'd0, x.pass ? 2'd3 : x.fv});
        chk("busy_done", {7'd0, o[7]}, 8'd0);
    endtask
    initial begin
        logic seen_done;
        xv = 1'bx;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        #2;
        chk("reset_or", o0, 8'd0);
        chk("reset_and", o1, 8'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        set_start(1'b0, 1'b1);
        @(negedge clk);
        set_start(1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_busy", {7'd0, o0[7]}, 8'd1);
        #2 rst_ = 1'b0;
        #1 chk("async_reset", o0, 8'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        run(1'b0, 0, 12, 1'b1, 2'd0, 1'b0, 1'b0);
        run(1'b0, 1, 6, 1'b0, 2'd1, 1'b0, 1'b0);
        if (xv === 1'b1) run(1'b0, 2, 12, 1'b1, 2'd0, 1'b0, 1'b0);
        else run(1'b0, 2, 12, 1'b0, 2'd3, xv, 1'b0);
        run(1'b1, 3, 12, 1'b1, 2'd0, 1'b0, 1'b0);
        run(1'b1, 0, 6, 1'b0, 2'd1, 1'b1, 1'b0);
        run(1'b0, 0, 12, 1'b1, 2'd0, 1'b0, 1'b1);
        mode0 = 0;
        set_start(1'b0, 1'b1);
        @(negedge clk);
        set_start(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("check_v2_busy", {7'd0, o0[7]}, 8'd1);
        chk("check_v2_vec", {6'd0, o0[1:0]}, 8'd2);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk("abort_idle", o0, 8'd0);
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done = seen_done | o0[6];
        end
        chk("abort_no_done", {7'd0, seen_done}, 8'd0);
        run(1'b0, 0, 12, 1'b1, 2'd0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for a 2-input primitive gate (or2, and2, ...).
- On a start command it drives the gate's A/B inputs through all four input combinations.
- For each combination it waits a programmable settle time, then samples the gate output and compares it against a parameterised truth table.
- It stops on the first mismatch and reports pass/fail plus the failing vector. It sits between a test/control master and one gate instance under test.

Parameters:
- TRUTH, 4'b1110, expected gate output indexed by {B,A}. Bit i is the expected Y for vector i. Default is OR.
- SETTLE, 2, cycles each vector is held before the compare cycle. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  reset, asynchronous and active-low.
- start  input  1  begin a test run. Sampled in IDLE or DONE; ignored while busy.
- abort  input  1  synchronous cancel. Returns to IDLE.
- gate_y  input  1  output of the gate under test.
- gate_a  output  1  drive to gate input A (= vec[0]).
- gate_b  output  1  drive to gate input B (= vec[1]).
- busy  output  1  high in WAIT or CHECK.
- done  output  1  high in DONE; result outputs are valid.
- pass  output  1  all four vectors matched. Valid when done=1.
- fail_vec  output  2  {B,A} index of the first mismatching vector. 0 when pass.
- fail_y  output  1  gate_y value captured at the failing compare. 0 when pass.

Behaviour:
- Reset (rst_=0, no clock needed):
  - state=IDLE, vec=0, cnt=0.
  - All outputs 0.
  - Reset mid-run discards the run entirely.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- FSM states:
  - IDLE: start=1 -> WAIT; vec<=0; gate_a/gate_b<=0; cnt<=SETTLE.
  - WAIT: cnt decrements each cycle. When cnt==1 at the edge -> CHECK. Each vector is therefore held SETTLE cycles in WAIT.
  - CHECK (one cycle): gate_y is compared to TRUTH[vec] at the closing edge using case-equality, so X or Z on gate_y is a mismatch.
    - Mismatch -> DONE; pass<=0; fail_vec<=vec; fail_y<=gate_y.
    - Match with vec==3 -> DONE; pass<=1; fail_vec<=0; fail_y<=0.
    - Match with vec<3 -> WAIT; vec<=vec+1; gate_a/gate_b updated; cnt<=SETTLE.
  - DONE: done=1; result outputs held. start=1 -> WAIT, same actions as from IDLE, and done/pass/fail_* cleared on the same edge. Otherwise stay in DONE.
- Gate drive: gate_a/gate_b change only on entry to WAIT. They hold their value through CHECK, and in DONE keep the last vector applied.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - A full passing run asserts done 4*(SETTLE+1) edges after the start edge: 12 edges at SETTLE=2.
  - A fail at vector k asserts done (k+1)*(SETTLE+1) edges after the start edge.
- abort=1 in any state -> IDLE at the next edge. All outputs go to 0 and done is not asserted. abort has priority over start and over the CHECK result.
- start held high: it restarts from DONE on the edge after done rises, so done is high for at least one cycle per run. start is ignored in WAIT/CHECK.
- Vector order by index {B,A}: 0=00, 1=(A=1,B=0), 2=(A=0,B=1), 3=11. vec never wraps; the run terminates at index 3.

Test Plan:
1. Reset: hold rst_=0, no clocks -> gate_a=gate_b=busy=done=pass=0 and fail_vec=0. Assert rst_=0 asynchronously mid-WAIT -> all outputs 0 immediately, before any clock edge.
2. Good OR model, TRUTH=4'b1110, SETTLE=2, one-cycle start pulse:
   - {gate_b,gate_a} = 00, 01, 10, 11 (A=1,B=0 second; A=0,B=1 third), each held 3 cycles.
   - busy=1 throughout; done=1 and pass=1 at edge 12 after the start edge; fail_vec=0, fail_y=0.
3. OR model with output stuck at 0 -> mismatch at vector 1: done at edge 6, pass=0, fail_vec=2'b01, fail_y=0, gate_a=1, gate_b=0 held in DONE.
4. Model driving gate_y=1'bx only for A=B=1 -> vectors 0-2 pass; done at edge 12 with pass=0, fail_vec=2'b11, fail_y=x.
5. Overrides and mid-run commands:
   - TRUTH=4'b1000 with an and2 model -> pass=1.
   - Same DUT with an or2 model -> fail_vec=2'b01, fail_y=1.
   - start pulsed during WAIT -> ignored, same timing as scenario 2.
6. abort during CHECK of vector 2 -> IDLE on the next edge, all outputs 0, done never rises. A subsequent start runs the full sequence from vector 0 and passes.
